// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: state set and LED patterns.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE, SEED, REWIND, PAUSE, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE
  } state_t;

  localparam logic [3:0] LED_OFF  = 4'b0000;
  localparam logic [3:0] LED_LOSE = 4'b1111;
  localparam logic [3:0] WIN_A    = 4'b0101;
  localparam logic [3:0] WIN_B    = 4'b1010;

  localparam int TIMER_W = 32;

endpackage

// File: rtl/simon_if.sv
// Controller-side bundle: player/generator inputs, generator strobes, display outputs.
interface simon_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic [3:0]       btn;
  logic [3:0]       seq;
  // Generator "randomize" strobe; named randomize_req because randomize is a built-in method name.
  logic             randomize_req;
  logic             next;
  logic             start_over;
  logic [3:0]       led;
  logic [LEN_W-1:0] level;
  logic             playing;
  logic             won;
  logic             lost;

  modport master (
    input  start, btn, seq,
    output randomize_req, next, start_over, led, level, playing, won, lost
  );

  modport slave (
    output start, btn, seq,
    input  randomize_req, next, start_over, led, level, playing, won, lost
  );
endinterface

// File: rtl/simon_timer.sv
// Cycle timer: restarts from zero on load, flags the last cycle of a period.
module simon_timer
  import simon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] period,
  output logic               done
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + TIMER_W'(1);
    end
  end

  assign done = en && (count_reg == period - TIMER_W'(1));

endmodule

// File: rtl/simon_controller.sv
// Simon game FSM: plays a growing prefix of the generator's sequence, then checks player presses.
module simon_controller
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int LEN_W          = 5,
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int GAP_CYCLES     = 25_000_000,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic      clk,
  input logic      rst,
  simon_if.master  bus
);

  localparam logic [3:0] ST_IDLE     = IDLE;
  localparam logic [3:0] ST_SEED     = SEED;
  localparam logic [3:0] ST_REWIND   = REWIND;
  localparam logic [3:0] ST_PAUSE    = PAUSE;
  localparam logic [3:0] ST_SHOW_ON  = SHOW_ON;
  localparam logic [3:0] ST_SHOW_OFF = SHOW_OFF;
  localparam logic [3:0] ST_INPUT    = INPUT;
  localparam logic [3:0] ST_WIN      = WIN;
  localparam logic [3:0] ST_LOSE     = LOSE;

  logic [3:0]         state_reg, state_next;
  logic [LEN_W-1:0]   level_reg, level_next;
  logic [LEN_W-1:0]   idx_reg, idx_next;
  logic               win_phase_reg, win_phase_next;
  logic               restart;
  logic               timer_en, timer_done;
  logic [TIMER_W-1:0] timer_period;

  logic               last_elem;
  assign last_elem = (idx_reg + LEN_W'(1)) == level_reg;

  always_comb begin
    state_next        = state_reg;
    level_next        = level_reg;
    idx_next          = idx_reg;
    win_phase_next    = win_phase_reg;
    restart           = 1'b0;
    timer_period      = '0;
    bus.randomize_req = 1'b0;
    bus.next          = 1'b0;
    bus.start_over    = 1'b0;
    bus.led           = LED_OFF;

    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_SEED;
      ST_SEED: begin
        bus.randomize_req = 1'b1;
        state_next        = ST_REWIND;
      end
      ST_REWIND: begin
        bus.start_over = 1'b1;
        level_next     = LEN_W'(1);
        idx_next       = '0;
        state_next     = ST_PAUSE;
      end
      ST_PAUSE: begin
        timer_period = TIMER_W'(GAP_CYCLES);
        if (timer_done) state_next = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        timer_period = TIMER_W'(SHOW_CYCLES);
        bus.led      = bus.seq;
        if (timer_done) state_next = ST_SHOW_OFF;
      end
      ST_SHOW_OFF: begin
        timer_period = TIMER_W'(GAP_CYCLES);
        if (timer_done) begin
          if (last_elem) begin
            bus.start_over = 1'b1;
            idx_next       = '0;
            state_next     = ST_INPUT;
          end else begin
            bus.next   = 1'b1;
            idx_next   = idx_reg + LEN_W'(1);
            state_next = ST_SHOW_ON;
          end
        end
      end
      ST_INPUT: begin
        timer_period = TIMER_W'(TIMEOUT_CYCLES);
        bus.led      = bus.btn;
        // A press always wins over a timeout landing in the same cycle.
        if (bus.btn != 4'b0000) begin
          if (bus.btn != bus.seq) begin
            state_next = ST_LOSE;
          end else if (!last_elem) begin
            bus.next = 1'b1;
            idx_next = idx_reg + LEN_W'(1);
            restart  = 1'b1;
          end else if (level_reg == LEN_W'(MAX_LEN)) begin
            win_phase_next = 1'b0;
            state_next     = ST_WIN;
          end else begin
            bus.start_over = 1'b1;
            level_next     = level_reg + LEN_W'(1);
            idx_next       = '0;
            state_next     = ST_PAUSE;
          end
        end else if (TIMEOUT_CYCLES > 0 && timer_done) begin
          state_next = ST_LOSE;
        end
      end
      ST_WIN: begin
        timer_period = TIMER_W'(SHOW_CYCLES);
        bus.led      = win_phase_reg ? WIN_B : WIN_A;
        if (bus.start) begin
          state_next = ST_SEED;
        end else if (timer_done) begin
          win_phase_next = ~win_phase_reg;
          restart        = 1'b1;
        end
      end
      ST_LOSE: begin
        bus.led = LED_LOSE;
        if (bus.start) state_next = ST_SEED;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      level_reg     <= '0;
      idx_reg       <= '0;
      win_phase_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      idx_reg       <= idx_next;
      win_phase_reg <= win_phase_next;
    end
  end

  assign timer_en = (state_reg != ST_IDLE) && (state_reg != ST_LOSE);

  simon_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   ((state_next != state_reg) || restart),
    .en     (timer_en),
    .period (timer_period),
    .done   (timer_done)
  );

  assign bus.level   = level_reg;
  assign bus.won     = (state_reg == ST_WIN);
  assign bus.lost    = (state_reg == ST_LOSE);
  assign bus.playing = (state_reg != ST_IDLE) && (state_reg != ST_WIN) && (state_reg != ST_LOSE);

endmodule

// File: tb/tb_simon_controller.sv
// Randomized self-checking bench for simon_controller with an LFSR sequence generator attached.
module tb_simon_controller;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int MAXL = 3;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  simon_if #(.LEN_W(5)) bus0 ();
  simon_if #(.LEN_W(5)) bus1 ();

  simon_controller #(.MAX_LEN(MAXL), .LEN_W(5), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
                     .TIMEOUT_CYCLES(0)) dut (.clk(clk), .rst(rst), .bus(bus0));
  simon_controller #(.MAX_LEN(MAXL), .LEN_W(5), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
                     .TIMEOUT_CYCLES(TO)) dut_to (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Reference: element k of a game seeded with 'seed'.
  function automatic logic [3:0] ref_elem(input logic [7:0] seed, input int k);
    logic [7:0] s = seed;
    for (int i = 0; i < k; i++) s = lfsr_step(s);
    return 4'b0001 << s[1:0];
  endfunction

  // Sequence generators (one per DUT); seeds are chosen by the bench.
  logic [7:0] seed_in0 = 8'h01, gseed0 = 8'h01, glfsr0 = 8'h01;
  logic [7:0] seed_in1 = 8'h01, gseed1 = 8'h01, glfsr1 = 8'h01;
  always_ff @(posedge clk) begin
    if (bus0.randomize_req) gseed0 <= seed_in0;
    if (bus0.start_over) glfsr0 <= gseed0;
    else if (bus0.next) glfsr0 <= lfsr_step(glfsr0);
    if (bus1.randomize_req) gseed1 <= seed_in1;
    if (bus1.start_over) glfsr1 <= gseed1;
    else if (bus1.next) glfsr1 <= lfsr_step(glfsr1);
  end
  assign bus0.seq = 4'b0001 << glfsr0[1:0];
  assign bus1.seq = 4'b0001 << glfsr1[1:0];

  initial begin
    bus0.start = 1'b0; bus0.btn = 4'b0;
    bus1.start = 1'b0; bus1.btn = 4'b0;
  end

  // Advance one clock; pulse inputs drop, outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    bus0.start = 1'b0; bus0.btn = 4'b0;
    bus1.start = 1'b0; bus1.btn = 4'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] v0, v1;
    rst = 1'b1;
    tick(); tick(); tick();
    v0 = {bus0.randomize_req, bus0.next, bus0.start_over, bus0.led};
    v1 = {bus1.randomize_req, bus1.next, bus1.start_over, bus1.led};
    total++;
    if (v0 !== 7'd0 || v1 !== 7'd0) begin
      bad++; $display("FAIL reset_outputs: got %b/%b want 0", v0, v1);
    end
    total++;
    if ({bus0.level, bus0.playing, bus0.won, bus0.lost} !== 8'd0) begin
      bad++; $display("FAIL reset_status: got level=%0d p=%b w=%b l=%b want all 0",
                      bus0.level, bus0.playing, bus0.won, bus0.lost);
    end
    rst = 1'b0;
    $display("reset: level=%0d led=%b", bus0.level, bus0.led);
  endtask

  // Start pulse from IDLE/WIN/LOSE; checks the randomize and rewind cycles.
  task automatic start_game(input logic [7:0] seed);
    seed_in0 = seed;
    tick();
    bus0.start = 1'b1;
    #1;
    tick();
    total++;
    if ({bus0.randomize_req, bus0.next, bus0.start_over} !== 3'b100) begin
      bad++; $display("FAIL seed_cycle: got rnd/nxt/so=%b want 100",
                      {bus0.randomize_req, bus0.next, bus0.start_over});
    end
    tick();
    total++;
    if ({bus0.randomize_req, bus0.next, bus0.start_over} !== 3'b001) begin
      bad++; $display("FAIL rewind_cycle: got rnd/nxt/so=%b want 001",
                      {bus0.randomize_req, bus0.next, bus0.start_over});
    end
    $display("start: seed=%h", seed);
  endtask

  // Pause plus playback of L elements; optional ignored noise on start/btn.
  task automatic play_round(input int L, input logic [7:0] seed, input bit noise);
    logic [6:0] got, exp;
    for (int g = 0; g < GAP; g++) begin
      tick();
      if (noise) begin
        bus0.start = 1'b1;
        bus0.btn = 4'($urandom_range(1, 15));
        #1;
      end
      got = {bus0.randomize_req, bus0.next, bus0.start_over, bus0.led};
      total++;
      if (got !== 7'd0 || bus0.level !== 5'(L) || bus0.playing !== 1'b1) begin
        bad++; $display("FAIL pause L=%0d g=%0d: got %b level=%0d want 0 level=%0d",
                        L, g, got, bus0.level, L);
      end
    end
    for (int k = 0; k < L; k++) begin
      for (int s = 0; s < SHOW; s++) begin
        tick();
        if (noise) begin
          bus0.start = 1'b1;
          bus0.btn = 4'($urandom_range(1, 15));
          #1;
        end
        got = {bus0.randomize_req, bus0.next, bus0.start_over, bus0.led};
        exp = {3'b000, ref_elem(seed, k)};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL show L=%0d k=%0d s=%0d: got %b want %b", L, k, s, got, exp);
        end
      end
      for (int g = 0; g < GAP; g++) begin
        tick();
        got = {bus0.randomize_req, bus0.next, bus0.start_over, bus0.led};
        exp = {1'b0, (g == GAP-1 && k < L-1), (g == GAP-1 && k == L-1), 4'b0000};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL gap L=%0d k=%0d g=%0d: got %b want %b", L, k, g, got, exp);
        end
      end
    end
    $display("playback: level=%0d done", L);
  endtask

  // Correct presses for every element of round L, starting on the first INPUT cycle.
  task automatic answer_round(input int L, input logic [7:0] seed);
    logic [6:0] got, exp;
    logic [3:0] b;
    for (int k = 0; k < L; k++) begin
      tick();
      b = ref_elem(seed, k);
      bus0.btn = b;
      #1;
      got = {bus0.randomize_req, bus0.next, bus0.start_over, bus0.led};
      exp = {1'b0, (k < L-1), (k == L-1 && L < MAXL), b};
      total++;
      if (got !== exp || bus0.level !== 5'(L)) begin
        bad++; $display("FAIL press L=%0d k=%0d: got %b level=%0d want %b level=%0d",
                        L, k, got, bus0.level, exp, L);
      end
      $display("press: level=%0d idx=%0d btn=%b", L, k, b);
    end
  endtask

  task automatic test_win();
    logic [7:0] seed;
    logic [3:0] exp_led;
    do_reset();
    seed = 8'($urandom_range(1, 255));
    start_game(seed);
    for (int L = 1; L <= MAXL; L++) begin
      play_round(L, seed, 1'b0);
      answer_round(L, seed);
    end
    for (int c = 0; c < 3*SHOW; c++) begin
      tick();
      exp_led = ((c / SHOW) % 2 == 0) ? 4'b0101 : 4'b1010;
      total++;
      if (bus0.led !== exp_led || bus0.won !== 1'b1 || bus0.playing !== 1'b0 || bus0.lost !== 1'b0) begin
        bad++; $display("FAIL win c=%0d: got led=%b won=%b playing=%b want led=%b won=1 playing=0",
                        c, bus0.led, bus0.won, bus0.playing, exp_led);
      end
    end
    total++;
    if (bus0.level !== 5'(MAXL)) begin
      bad++; $display("FAIL win_level: got %0d want %0d", bus0.level, MAXL);
    end
    seed = 8'($urandom_range(1, 255));
    start_game(seed);
    tick();
    total++;
    if (bus0.level !== 5'd1 || bus0.won !== 1'b0) begin
      bad++; $display("FAIL restart_from_win: got level=%0d won=%b want level=1 won=0",
                      bus0.level, bus0.won);
    end
    $display("win: restart level=%0d", bus0.level);
  endtask

  task automatic test_lose();
    logic [7:0] seed;
    logic [3:0] wrong, e1;
    do_reset();
    seed = 8'($urandom_range(1, 255));
    start_game(seed);
    play_round(1, seed, 1'b0);
    answer_round(1, seed);
    play_round(2, seed, 1'b0);
    tick();
    bus0.btn = ref_elem(seed, 0);
    #1;
    total++;
    if (bus0.next !== 1'b1) begin
      bad++; $display("FAIL lose_first_press: got next=%b want 1", bus0.next);
    end
    tick();
    e1 = ref_elem(seed, 1);
    wrong = {e1[2:0], e1[3]};
    bus0.btn = wrong;
    #1;
    total++;
    if ({bus0.randomize_req, bus0.next, bus0.start_over} !== 3'b000 || bus0.led !== wrong) begin
      bad++; $display("FAIL wrong_press: got strobes=%b led=%b want 000 led=%b",
                      {bus0.randomize_req, bus0.next, bus0.start_over}, bus0.led, wrong);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus0.lost !== 1'b1 || bus0.led !== 4'b1111 || bus0.level !== 5'd2 || bus0.playing !== 1'b0) begin
        bad++; $display("FAIL lose_state c=%0d: got lost=%b led=%b level=%0d want lost=1 led=1111 level=2",
                        c, bus0.lost, bus0.led, bus0.level);
      end
    end
    $display("lose: wrong btn=%b expected=%b", wrong, e1);
    seed = 8'($urandom_range(1, 255));
    start_game(seed);
    play_round(1, seed, 1'b0);
    tick();
    bus0.btn = 4'b0011;
    #1;
    tick();
    total++;
    if (bus0.lost !== 1'b1 || bus0.led !== 4'b1111 || bus0.level !== 5'd1) begin
      bad++; $display("FAIL multi_hot: got lost=%b led=%b level=%0d want lost=1 led=1111 level=1",
                      bus0.lost, bus0.led, bus0.level);
    end
    $display("lose: multi-hot btn=0011");
  endtask

  task automatic test_ignore_and_reset();
    logic [7:0] seed;
    logic [6:0] got;
    do_reset();
    seed = 8'($urandom_range(1, 255));
    start_game(seed);
    play_round(1, seed, 1'b1);
    answer_round(1, seed);
    for (int c = 0; c < GAP + 2; c++) tick();
    total++;
    if (bus0.led !== ref_elem(seed, 0)) begin
      bad++; $display("FAIL pre_reset_show: got led=%b want %b", bus0.led, ref_elem(seed, 0));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {bus0.randomize_req, bus0.next, bus0.start_over, bus0.led};
    total++;
    if (got !== 7'd0 || bus0.level !== 5'd0 || bus0.playing !== 1'b0 || bus0.won !== 1'b0 || bus0.lost !== 1'b0) begin
      bad++; $display("FAIL mid_show_reset: got %b level=%0d playing=%b want 0 level=0 playing=0",
                      got, bus0.level, bus0.playing);
    end
    tick();
    bus0.btn = 4'b0100;
    #1;
    got = {bus0.randomize_req, bus0.next, bus0.start_over, bus0.led};
    tick();
    total++;
    if (got !== 7'd0 || bus0.playing !== 1'b0) begin
      bad++; $display("FAIL idle_btn: got %b playing=%b want 0 playing=0", got, bus0.playing);
    end
    $display("reset mid-show: level=%0d led=%b", bus0.level, bus0.led);
  endtask

  task automatic test_timeout();
    logic [7:0] seed;
    int found;
    do_reset();
    seed = 8'($urandom_range(1, 255));
    seed_in1 = seed;
    tick();
    bus1.start = 1'b1;
    #1;
    tick();
    total++;
    if (bus1.randomize_req !== 1'b1) begin
      bad++; $display("FAIL to_seed: got randomize=%b want 1", bus1.randomize_req);
    end
    tick();
    found = -1;
    for (int i = 0; i < 40 && found < 0; i++) begin
      tick();
      if (bus1.start_over) found = i;
    end
    total++;
    if (found != GAP + SHOW + GAP - 1) begin
      bad++; $display("FAIL to_playback1: got end at %0d want %0d", found, GAP + SHOW + GAP - 1);
    end
    for (int c = 0; c < TO - 1; c++) tick();
    tick();
    bus1.btn = ref_elem(seed, 0);
    #1;
    total++;
    if (bus1.start_over !== 1'b1 || bus1.lost !== 1'b0) begin
      bad++; $display("FAIL to_late_press: got start_over=%b lost=%b want 1 0", bus1.start_over, bus1.lost);
    end
    found = -1;
    for (int i = 0; i < 60 && found < 0; i++) begin
      tick();
      if (bus1.start_over) found = i;
    end
    total++;
    if (found != GAP + 2*(SHOW + GAP) - 1) begin
      bad++; $display("FAIL to_playback2: got end at %0d want %0d", found, GAP + 2*(SHOW + GAP) - 1);
    end
    tick();
    bus1.btn = ref_elem(seed, 0);
    #1;
    total++;
    if (bus1.next !== 1'b1) begin
      bad++; $display("FAIL to_press2: got next=%b want 1", bus1.next);
    end
    for (int c = 0; c <= TO; c++) begin
      tick();
      total++;
      if (bus1.lost !== (c == TO)) begin
        bad++; $display("FAIL to_window c=%0d: got lost=%b want %b", c, bus1.lost, (c == TO));
      end
    end
    total++;
    if (bus1.level !== 5'd2 || bus1.led !== 4'b1111) begin
      bad++; $display("FAIL to_lose_state: got level=%0d led=%b want 2 1111", bus1.level, bus1.led);
    end
    $display("timeout: lost=%b level=%0d", bus1.lost, bus1.level);
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_ignore_and_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
